// File: rtl/alu_pkg.sv
// Shared types for the ALU command-issue slice: operand widths, command struct, issue FSM states.
package alu_pkg;

    localparam int ALU_W  = 16;
    localparam int CTRL_W = 4;

    typedef struct packed {
        logic [ALU_W-1:0]  a;
        logic [ALU_W-1:0]  b;
        logic [CTRL_W-1:0] ctrl;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } alu_issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty come from registered occupancy only, so a push
// offered while full is refused even if a pop happens on the same edge.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  alu_cmd_t cmd_i,
    input  logic     pop_i,
    output alu_cmd_t cmd_o,
    output logic     full_o,
    output logic     empty_o
);
    localparam int AW = $clog2(DEPTH);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign cmd_o   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= cmd_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue.sv
// One-at-a-time command issue into a fixed-latency registered ALU, with a valid/ready result register.
// Optional ALU_ISSUE_STATS_EN adds a wrapping 16-bit count of issued commands (stat_issued).
module alu_issue
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALU_W-1:0]  in_a,
    input  logic [ALU_W-1:0]  in_b,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [ALU_W-1:0]  alu_answer,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ALU_W-1:0]  res_data,
    output logic [CTRL_W-1:0] res_ctrl,
    output logic              busy
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_issued
`endif
);
    alu_cmd_t          in_cmd, fifo_head, op_q;
    logic              fifo_full, fifo_empty, pop, capture;
    alu_issue_state_t  state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              res_valid_q, res_valid_d;
    logic [ALU_W-1:0]  res_data_q;
    logic [CTRL_W-1:0] res_ctrl_q;

    assign in_cmd = {in_a, in_b, in_ctrl};

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .cmd_i   (in_cmd),
        .pop_i   (pop),
        .cmd_o   (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                capture     = 1'b1;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            // Handshake edge doubles as the next issue edge when work is queued.
            DONE: if (res_ready) begin
                res_valid_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) cnt_d = 4'(ALU_LAT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_ctrl_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            if (pop) op_q <= fifo_head;
            if (capture) begin
                res_data_q <= alu_answer;
                res_ctrl_q <= op_q.ctrl;
            end
        end
    end

    assign in_ready  = !fifo_full;
    assign alu_a     = op_q.a;
    assign alu_b     = op_q.b;
    assign alu_ctrl  = op_q.ctrl;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_ctrl  = res_ctrl_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   stat_q <= '0;
        else if (pop) stat_q <= stat_q + 16'd1;
    end

    assign stat_issued = stat_q;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a one-cycle registered ALU model (add on 0100, sub on 1000).
module tb_alu_issue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_a, in_b;
    logic [3:0]  in_ctrl;
    logic [15:0] alu_a, alu_b, alu_answer;
    logic [3:0]  alu_ctrl;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_ctrl;
    logic        busy;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued;
`endif

    int errors = 0;
    int checks = 0;

    alu_issue #(.DEPTH(4), .ALU_LAT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_ctrl    (in_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_answer (alu_answer),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_ctrl   (res_ctrl),
        .busy       (busy)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .stat_issued(stat_issued)
`endif
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_answer <= '0;
        else case (alu_ctrl)
            4'b0100: alu_answer <= alu_a + alu_b;
            4'b1000: alu_answer <= alu_a - alu_b;
            default: alu_answer <= '0;
        endcase
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
        in_a = a; in_b = b; in_ctrl = c; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string name);
        int n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout res_valid=%b expected 1", name, res_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ctrl = '0; res_ready = 1'b0;
        #2;
        checks++;
        if ({in_ready, res_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_flags in_ready/res_valid/busy=%b expected 100", {in_ready, res_valid, busy});
        end
        checks++;
        if ({alu_a, alu_b, alu_ctrl, res_data, res_ctrl} !== 56'd0) begin
            errors++;
            $display("FAIL reset_data alu=%h/%h/%h res=%h/%h expected all 0", alu_a, alu_b, alu_ctrl, res_data, res_ctrl);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        res_ready = 1'b1;
        push(16'd10, 16'd20, 4'b0100);
        @(negedge clk);
        checks++;
        if (alu_a !== 16'd10 || alu_b !== 16'd20 || alu_ctrl !== 4'b0100) begin
            errors++;
            $display("FAIL single_operands got %0d/%0d/%b expected 10/20/0100", alu_a, alu_b, alu_ctrl);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early res_valid=%b expected 0 two cycles after push", res_valid);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== 16'd30 || res_ctrl !== 4'b0100) begin
            errors++;
            $display("FAIL single_result valid=%b data=%0d ctrl=%b expected 1/30/0100", res_valid, res_data, res_ctrl);
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_drain valid=%b busy=%b expected 0/0", res_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, nvalid = 0;
        logic [15:0] d1 = '0, d2 = '0;
        logic [3:0]  c1 = '0, c2 = '0;
        res_ready = 1'b1;
        push(16'd10, 16'd20, 4'b0100);
        push(16'd30, 16'd9, 4'b1000);
        // Now just after edge P+1, where P is the first push edge.
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (res_valid) begin
                nvalid++;
                if (t1 < 0) begin t1 = k; d1 = res_data; c1 = res_ctrl; end
                else begin t2 = k; d2 = res_data; c2 = res_ctrl; end
            end
        end
        checks++;
        if (t1 !== 3 || d1 !== 16'd30 || c1 !== 4'b0100) begin
            errors++;
            $display("FAIL b2b_first cycle=%0d data=%0d ctrl=%b expected 3/30/0100", t1, d1, c1);
        end
        checks++;
        if (t2 !== 6 || d2 !== 16'd21 || c2 !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_second cycle=%0d data=%0d ctrl=%b expected 6/21/1000", t2, d2, c2);
        end
        checks++;
        if (nvalid !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count valid_cycles=%0d busy=%b expected 2/0", nvalid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] opa [6] = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600};
        logic [15:0] opb [6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        logic [3:0]  opc [6] = '{4'b0100, 4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b1000};
        logic [15:0] expd[6] = '{16'd101, 16'd198, 16'd303, 16'd396, 16'd505, 16'd594};
        logic [19:0] got[$];
        int acc = 0;
        logic ok, pend;
        res_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_a = opa[acc]; in_b = opb[acc]; in_ctrl = opc[acc]; in_valid = 1'b1;
            ok = in_ready;
            @(negedge clk);
            if (ok) acc++;
        end
        checks++;
        if (acc !== 5 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full accepted=%0d in_ready=%b expected 5/0", acc, in_ready);
        end
        res_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (res_valid) got.push_back({res_ctrl, res_data});
            pend = in_valid && in_ready;
            @(negedge clk);
            if (pend) begin
                in_valid = 1'b0;
                acc++;
            end
        end
        checks++;
        if (acc !== 6 || got.size() !== 6) begin
            errors++;
            $display("FAIL bp_counts accepted=%0d results=%0d expected 6/6", acc, got.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== {opc[i], expd[i]}) begin
                errors++;
                $display("FAIL bp_result%0d got=%h expected %h", i, (i < got.size()) ? got[i] : 20'hxxxxx, {opc[i], expd[i]});
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_result_hold();
        logic held = 1'b1;
        res_ready = 1'b0;
        push(16'd7, 16'd3, 4'b1000);
        push(16'd1, 16'd1, 4'b0100);
        wait_res("hold_first");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== 16'd4 || res_ctrl !== 4'b1000 || alu_a !== 16'd7) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL hold_stable valid=%b data=%0d ctrl=%b alu_a=%0d expected 1/4/1000/7", res_valid, res_data, res_ctrl, alu_a);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || alu_a !== 16'd1 || alu_ctrl !== 4'b0100) begin
            errors++;
            $display("FAIL hold_pop valid=%b alu_a=%0d alu_ctrl=%b expected 0/1/0100", res_valid, alu_a, alu_ctrl);
        end
        wait_res("hold_second");
        checks++;
        if (res_data !== 16'd2 || res_ctrl !== 4'b0100) begin
            errors++;
            $display("FAIL hold_second data=%0d ctrl=%b expected 2/0100", res_data, res_ctrl);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic spurious = 1'b0;
        res_ready = 1'b0;
        push(16'd5, 16'd5, 4'b0100);
        push(16'd6, 16'd6, 4'b0100);
        push(16'd7, 16'd7, 4'b1000);
        checks++;
        if (busy !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_precond busy=%b res_valid=%b expected 1/0", busy, res_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, res_valid, busy} !== 3'b100 || {alu_a, alu_b, alu_ctrl, res_data, res_ctrl} !== 56'd0) begin
            errors++;
            $display("FAIL rst_async flags=%b alu_a=%0d alu_ctrl=%b res_data=%0d expected 100/0/0/0",
                     {in_ready, res_valid, busy}, alu_a, alu_ctrl, res_data);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0 || alu_a !== 16'd0) spurious = 1'b1;
        end
        checks++;
        if (spurious !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet activity after release res_valid=%b busy=%b alu_a=%0d expected none", res_valid, busy, alu_a);
        end
    endtask

`ifdef ALU_ISSUE_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        #1;
        checks++;
        if (stat_issued !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got=%h expected 0000", stat_issued);
        end
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        push(16'd1, 16'd2, 4'b0100);
        push(16'd3, 16'd4, 4'b0100);
        push(16'd5, 16'd6, 4'b1000);
        repeat (12) @(negedge clk);
        checks++;
        if (stat_issued !== 16'd3) begin
            errors++;
            $display("FAIL stats_three got=%0d expected 3", stat_issued);
        end
        force dut.stat_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_q;
        push(16'd8, 16'd8, 4'b0100);
        repeat (6) @(negedge clk);
        checks++;
        if (stat_issued !== 16'h0000) begin
            errors++;
            $display("FAIL stats_wrap got=%h expected 0000", stat_issued);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_result_hold();
        test_reset_midflight();
`ifdef ALU_ISSUE_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Command-issue stage sitting directly upstream of the 16-bit `ALU`. It buffers {A, B, Control} commands in a small FIFO, drives the ALU operand ports one command at a time, and waits the ALU's fixed register latency. It then captures `Answer` into a result register that is presented downstream through a valid/ready handshake. It is not pipelined: exactly one command is in flight at a time.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `ALU_LAT`, 1: ALU clock edges from operands applied to `Answer` updated; 1..15.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: command offered.
- `in_ready` out 1: FIFO not full.
- `in_a` in 16: operand A.
- `in_b` in 16: operand B.
- `in_ctrl` in 4: ALU control code.
- `alu_a` out 16: to ALU `A`.
- `alu_b` out 16: to ALU `B`.
- `alu_ctrl` out 4: to ALU `Control`.
- `alu_answer` in 16: from ALU `Answer`.
- `res_valid` out 1: result held.
- `res_ready` in 1: downstream accepts.
- `res_data` out 16: captured answer.
- `res_ctrl` out 4: control code of that result.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.

## Operation
- Push when `in_valid && in_ready`. No bypass: a pushed entry is poppable from the next cycle.
- The FSM has three states:
  - IDLE: if FIFO non-empty, pop the head into operand registers (`alu_a/b/ctrl`), load `cnt = ALU_LAT`, and go to WAIT.
  - WAIT: if `cnt != 0`, decrement it. If `cnt == 0`, capture `res_data <= alu_answer`, `res_ctrl <= alu_ctrl`, set `res_valid = 1`, and go to DONE.
  - DONE: hold the result until `res_valid && res_ready`. On that edge, clear `res_valid`. Then, if the FIFO is non-empty, pop immediately and go to WAIT (back-to-back); otherwise go to IDLE.
- Operand registers hold their value from pop until the next pop. They are never zeroed between commands.
- `res_data`/`res_ctrl` are stable while `res_valid` is high.
- Arithmetic: the block performs none. `cnt` is 4 bits. FIFO pointers are `$clog2(DEPTH)` bits with natural wrap. The occupancy count is `$clog2(DEPTH)+1` bits.

## Timing
- Reset values: `in_ready = 1`, all other outputs 0, FSM = IDLE, FIFO empty.
- Pop at edge E0 → ALU samples at E1 → `Answer` changes after E(ALU_LAT) → captured at E(ALU_LAT+1).
- Push-to-`res_valid`: ALU_LAT+2 cycles with an empty FIFO and IDLE state.
- Back-to-back issue interval with `res_ready` tied high: ALU_LAT+2 cycles.
- FIFO full: `in_ready = 0`. A push offered while full is not accepted, even if a pop occurs on the same edge (`in_ready` is registered-state-derived).
- Push and pop on the same edge with 0 < occupancy < DEPTH: both occur and the count is unchanged.
- `res_ready` high with `res_valid` low is ignored.
- `rst_n` asserted mid-operation: FIFO contents and the in-flight command are discarded immediately. Outputs return to reset values asynchronously. No result is emitted for a lost command.

## Configuration
- `ALU_ISSUE_STATS_EN` defined: adds output `stat_issued` (16 bits). It increments on every pop, wraps 0xFFFF→0, and resets to 0.
- Macro undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W = 16`, `CTRL_W = 4`.
  - Packed struct `alu_cmd_t` {a, b, ctrl}.
  - FSM enum `alu_issue_state_t` {IDLE, WAIT, DONE}.
- Sub-module `alu_cmd_fifo`: synchronous FIFO of `alu_cmd_t` with `DEPTH`, `full`/`empty`, push/pop, async active-low reset. The FSM, latency counter and result register stay in `alu_issue`.

## Test plan
The bench uses a registered ALU model with `ALU_LAT = 1`: `Answer <= A+B` for ctrl 4'b0100 and `Answer <= A-B` for ctrl 4'b1000.
- Single add: after reset, push {10, 20, 0100} with `res_ready = 1` → `alu_a = 10`, `alu_b = 20`, `alu_ctrl = 0100` one cycle after the push; `res_valid` is high exactly 3 cycles after the push with `res_data = 30`, `res_ctrl = 0100`.
- Back-to-back: push {10, 20, 0100} then {30, 9, 1000} on consecutive cycles → results 30 then 21, in order, 3 cycles apart.
- Backpressure/full: `res_ready = 0`, push 6 commands → `in_ready` drops after 4 accepted plus 1 popped. The 6th is held off until `res_ready` rises. Results arrive in push order with none lost or duplicated.
- Result hold: `res_ready` low for 5 cycles while `res_valid` is high → `res_data` and `res_ctrl` are unchanged; the next pop occurs on the handshake edge.
- Reset mid-flight: assert `rst_n = 0` during WAIT with 2 entries queued → all outputs go to 0 and `in_ready = 1` immediately. After release no `res_valid` appears without new pushes.
- Stats (with `ALU_ISSUE_STATS_EN`): 3 commands → `stat_issued = 3`. Force the counter to 0xFFFF and issue one more → `stat_issued = 0`.
